rat_rollback_ctrl: RTL

- Sequencer for the register alias table's per-map restore port.
- On a pipeline flush it walks the squashed ROB window from youngest to oldest entry. It reads each entry's (new, old) physical register pair and issues one restore per cycle: new map invalidated, old map made valid and visible again.
- Sits between the ROB/commit stage and the RAT. It drives the RAT restore interface and stalls rename while busy.

---
 rtl/rat_rollback_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rat_rollback_ctrl.sv
// Purpose : walks a squashed ROB window youngest->oldest after a flush and
//           issues one RAT per-map restore (new invalidated, old revalidated)
//           per entry that renamed a destination.
// Latency : flush_req to rollback_done = N+2 cycles for an N-entry window,
//           1 cycle for an empty window (tail == flush id).
// Backpressure: none accepted; the RAT restore port takes one strobe per
//           cycle. rollback_busy stalls rename/commit for the whole rollback.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush_req_i                   start rollback, honoured in IDLE only
//   flush_rob_id_i                oldest squashed ROB entry (undone last)
//   rob_tail_id_i                 next free ROB slot at flush time
//   rob_read_id_o                 ROB entry being read (0 outside WALK)
//   rob_read_has_dest_i           same-cycle reply: entry renamed a dest
//   rob_read_new_phy_id_i         same-cycle reply: allocated phy id
//   rob_read_old_phy_id_i         same-cycle reply: previous phy id
//   commit_rat_restore_new_phy_id_o / _old_phy_id_o   restore ids to RAT
//   commit_rat_restore_map_o      restore strobe to RAT
//   rollback_busy_o               high in WALK, DRAIN and DONE
//   rollback_done_o               one-cycle completion pulse
//   rollback_restore_cnt_o        restores issued in current/last rollback
module rat_rollback_ctrl #(
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int ROB_ID_WIDTH     = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_req_i,
    input  logic [ROB_ID_WIDTH-1:0]       flush_rob_id_i,
    input  logic [ROB_ID_WIDTH-1:0]       rob_tail_id_i,
    output logic [ROB_ID_WIDTH-1:0]       rob_read_id_o,
    input  logic                          rob_read_has_dest_i,
    input  logic [PHY_REG_ID_WIDTH-1:0]   rob_read_new_phy_id_i,
    input  logic [PHY_REG_ID_WIDTH-1:0]   rob_read_old_phy_id_i,
    output logic [PHY_REG_ID_WIDTH-1:0]   commit_rat_restore_new_phy_id_o,
    output logic [PHY_REG_ID_WIDTH-1:0]   commit_rat_restore_old_phy_id_o,
    output logic                          commit_rat_restore_map_o,
    output logic                          rollback_busy_o,
    output logic                          rollback_done_o,
    output logic [ROB_ID_WIDTH:0]         rollback_restore_cnt_o
);

    localparam int CNT_W = ROB_ID_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [ROB_ID_WIDTH-1:0]       ptr_q, ptr_d;     // entry read this cycle
    logic [ROB_ID_WIDTH-1:0]       tgt_q, tgt_d;     // oldest entry, last to undo
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    // Single output stage between the ROB read and the RAT restore port.
    logic                          stg_vld_q, stg_vld_d;
    logic [PHY_REG_ID_WIDTH-1:0]   stg_new_q, stg_new_d;
    logic [PHY_REG_ID_WIDTH-1:0]   stg_old_q, stg_old_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        stg_vld_d = 1'b0;
        stg_new_d = stg_new_q;
        stg_old_d = stg_old_q;

        case (state_q)
            S_IDLE: begin
                if (flush_req_i) begin
                    tgt_d = flush_rob_id_i;
                    // Youngest live entry is one below the tail, wrapping
                    // naturally through the modulo-depth pointer width.
                    ptr_d = rob_tail_id_i - ROB_ID_WIDTH'(1);
                    cnt_d = '0;
                    // Equal pointers mean an empty window; the ROB never
                    // presents a full-window flush this way.
                    if (rob_tail_id_i == flush_rob_id_i) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WALK;
                    end
                end
            end
            S_WALK: begin
                stg_vld_d = rob_read_has_dest_i;
                // Ids only move on a real restore so they hold their last
                // value while the strobe is low.
                if (rob_read_has_dest_i) begin
                    stg_new_d = rob_read_new_phy_id_i;
                    stg_old_d = rob_read_old_phy_id_i;
                    // Counter steps together with the strobe becoming visible.
                    cnt_d     = cnt_q + CNT_W'(1);
                end
                if (ptr_q == tgt_q) begin
                    state_d = S_DRAIN;
                end else begin
                    ptr_d = ptr_q - ROB_ID_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // The stage register presents the last entry's restore here.
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            stg_vld_q <= 1'b0;
            stg_new_q <= '0;
            stg_old_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            stg_vld_q <= stg_vld_d;
            stg_new_q <= stg_new_d;
            stg_old_q <= stg_old_d;
        end
    end

    assign rob_read_id_o                   = (state_q == S_WALK) ? ptr_q : '0;
    assign commit_rat_restore_map_o        = stg_vld_q;
    assign commit_rat_restore_new_phy_id_o = stg_new_q;
    assign commit_rat_restore_old_phy_id_o = stg_old_q;
    assign rollback_busy_o                 = (state_q != S_IDLE);
    assign rollback_done_o                 = (state_q == S_DONE);
    assign rollback_restore_cnt_o          = cnt_q;

endmodule
